// File: rtl/rpn_evaluator_pkg.sv
// Shared codes for the RPN evaluator: ALU opcodes, instruction kinds, FSM states.
// The kind-to-opcode helper keeps the instruction encoding out of the top module.
package rpn_evaluator_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic [2:0] {
    KIND_PUSH_CONST = 3'b000,
    KIND_PUSH_X     = 3'b001,
    KIND_ADD        = 3'b010,
    KIND_SUB        = 3'b011,
    KIND_MUL        = 3'b100,
    KIND_DIV        = 3'b101,
    KIND_ILLEGAL    = 3'b110,
    KIND_END        = 3'b111
  } kind_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ALU_ISSUE,
    S_ALU_WAIT,
    S_WRITEBACK,
    S_FINISH
  } state_e;

  function automatic logic [2:0] kind_to_op(input kind_e kind);
    case (kind)
      KIND_SUB: kind_to_op = OP_SUB;
      KIND_MUL: kind_to_op = OP_MUL;
      KIND_DIV: kind_to_op = OP_DIV;
      default:  kind_to_op = OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/rpn_evaluator_stack.sv
// Operand stack: register array with stack pointer, push and replace-top-two ports.
// The caller checks full/count before pushing or replacing; the stack guards anyway.
module rpn_evaluator_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  localparam int SPW  = $clog2(DEPTH + 1),
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear_i,
  input  logic           push_i,
  input  logic [W-1:0]   push_data_i,
  input  logic           replace_i,
  input  logic [W-1:0]   replace_data_i,
  output logic [SPW-1:0] count_o,
  output logic           full_o,
  output logic [W-1:0]   top_o,
  output logic [W-1:0]   lower_o,
  output logic [W-1:0]   bottom_o
);

  logic [W-1:0]   mem_q [DEPTH];
  logic [SPW-1:0] sp_q;
  logic [IW-1:0]  top_idx;
  logic [IW-1:0]  lower_idx;

  assign top_idx   = IW'(sp_q - SPW'(1));
  assign lower_idx = IW'(sp_q - SPW'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      sp_q <= '0;
    end else if (push_i && !full_o) begin
      mem_q[IW'(sp_q)] <= push_data_i;
      sp_q             <= sp_q + SPW'(1);
    end else if (replace_i && (sp_q >= SPW'(2))) begin
      // The result replaces the lower operand; the top slot becomes free.
      mem_q[lower_idx] <= replace_data_i;
      sp_q             <= sp_q - SPW'(1);
    end
  end

  assign count_o  = sp_q;
  assign full_o   = (sp_q == SPW'(DEPTH));
  assign top_o    = mem_q[top_idx];
  assign lower_o  = mem_q[lower_idx];
  assign bottom_o = mem_q[0];

endmodule

// File: rtl/rpn_evaluator.sv
// RPN program sequencer: fetches from a synchronous ROM, drives the external ALU,
// and returns f(x) with a one-cycle done pulse.
//   state       | meaning
//   S_IDLE      | waiting for start
//   S_FETCH     | prog_addr = pc, ROM read in flight
//   S_DECODE    | prog_data valid, push or dispatch
//   S_ALU_ISSUE | pulse alu_start once alu_done is high
//   S_ALU_WAIT  | skip first cycle, then capture on alu_done
//   S_WRITEBACK | replace top two with captured result
//   S_FINISH    | done pulse, busy low
module rpn_evaluator
  import rpn_evaluator_pkg::*;
#(
  parameter int INTEGER_PART_WIDTH    = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8,
  parameter int STACK_DEPTH           = 8,
  parameter int PROG_ADDR_WIDTH       = 8,
  localparam int NW  = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
  localparam int SPW = $clog2(STACK_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [NW-1:0]              x,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [NW-1:0]              result,
  output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
  input  logic [NW+2:0]              prog_data,
  output logic                       alu_start,
  output logic [2:0]                 alu_op,
  output logic [NW-1:0]              alu_a,
  output logic [NW-1:0]              alu_b,
  input  logic                       alu_done,
  input  logic [NW-1:0]              alu_result
);

  state_e                     state_q, state_d;
  logic [PROG_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [NW-1:0]              x_q, x_d;
  logic                       error_q, error_d;
  logic [NW-1:0]              result_q, result_d;
  logic [2:0]                 op_q, op_d;
  logic [NW-1:0]              cap_q, cap_d;
  logic                       first_q, first_d;

  kind_e          kind;
  logic [NW-1:0]  imm;
  logic           stk_clear, stk_push, stk_replace, stk_full;
  logic [NW-1:0]  stk_push_data, stk_top, stk_lower, stk_bottom;
  logic [SPW-1:0] stk_count;
  logic           pc_last;

  assign kind    = kind_e'(prog_data[NW+2:NW]);
  assign imm     = prog_data[NW-1:0];
  assign pc_last = (pc_q == '1);

  rpn_evaluator_stack #(
    .W     (NW),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear_i        (stk_clear),
    .push_i         (stk_push),
    .push_data_i    (stk_push_data),
    .replace_i      (stk_replace),
    .replace_data_i (cap_q),
    .count_o        (stk_count),
    .full_o         (stk_full),
    .top_o          (stk_top),
    .lower_o        (stk_lower),
    .bottom_o       (stk_bottom)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      x_q      <= '0;
      error_q  <= 1'b0;
      result_q <= '0;
      op_q     <= OP_ADD;
      cap_q    <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      x_q      <= x_d;
      error_q  <= error_d;
      result_q <= result_d;
      op_q     <= op_d;
      cap_q    <= cap_d;
      first_q  <= first_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    x_d           = x_q;
    error_d       = error_q;
    result_d      = result_q;
    op_d          = op_q;
    cap_d         = cap_q;
    first_d       = 1'b0;
    stk_clear     = 1'b0;
    stk_push      = 1'b0;
    stk_push_data = (kind == KIND_PUSH_X) ? x_q : imm;
    stk_replace   = 1'b0;
    alu_start     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d       = x;
          pc_d      = '0;
          error_d   = 1'b0;
          stk_clear = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (kind)
          KIND_PUSH_CONST, KIND_PUSH_X: begin
            if (stk_full || pc_last) begin
              error_d = 1'b1;
              state_d = S_FINISH;
            end else begin
              stk_push = 1'b1;
              pc_d     = pc_q + 1'b1;
              state_d  = S_FETCH;
            end
          end
          KIND_ADD, KIND_SUB, KIND_MUL, KIND_DIV: begin
            if (stk_count < SPW'(2)) begin
              error_d = 1'b1;
              state_d = S_FINISH;
            end else begin
              op_d    = kind_to_op(kind);
              state_d = S_ALU_ISSUE;
            end
          end
          KIND_END: begin
            if (stk_count == SPW'(1)) result_d = stk_bottom;
            else                      error_d  = 1'b1;
            state_d = S_FINISH;
          end
          default: begin
            error_d = 1'b1;
            state_d = S_FINISH;
          end
        endcase
      end
      S_ALU_ISSUE: begin
        if (alu_done) begin
          alu_start = 1'b1;
          first_d   = 1'b1;
          state_d   = S_ALU_WAIT;
        end
      end
      S_ALU_WAIT: begin
        // The ALU still shows done in the cycle right after alu_start.
        if (!first_q && alu_done) begin
          cap_d   = alu_result;
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        stk_replace = 1'b1;
        if (pc_last) begin
          error_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done      = (state_q == S_FINISH);
  assign error     = error_q;
  assign result    = result_q;
  assign prog_addr = pc_q;
  assign alu_op    = op_q;
  assign alu_a     = stk_lower;
  assign alu_b     = stk_top;

endmodule

// File: tb/tb_rpn_evaluator.sv
// Directed bench for rpn_evaluator with a queue-based program interpreter as reference
// and a behavioural ALU that drops done one cycle late.
module tb_rpn_evaluator;

  localparam logic [2:0] K_CONST = 3'b000;
  localparam logic [2:0] K_X     = 3'b001;
  localparam logic [2:0] K_ADD   = 3'b010;
  localparam logic [2:0] K_SUB   = 3'b011;
  localparam logic [2:0] K_MUL   = 3'b100;
  localparam logic [2:0] K_DIV   = 3'b101;
  localparam logic [2:0] K_BAD   = 3'b110;
  localparam logic [2:0] K_END   = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] x = '0;
  logic        busy, done, error;
  logic [15:0] result;
  logic [7:0]  prog_addr;
  logic [18:0] prog_data = '0;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic        alu_done;
  logic [15:0] alu_result = 16'hdead;

  rpn_evaluator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .x          (x),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .result     (result),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_done   (alu_done),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_alu   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Fixed-point Q8.8 arithmetic shared by the bench ALU and the reference model.
  function automatic logic [15:0] fx(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      3'd0:    r = sa + sb;
      3'd1:    r = sa - sb;
      3'd2:    r = (sa * sb) >>> 8;
      default: r = (sb == 0) ? 0 : (sa * 256) / sb;
    endcase
    return r[15:0];
  endfunction

  logic [18:0] rom [256];
  always @(posedge clk) prog_data <= rom[prog_addr];

  int          alu_cnt = 0;
  logic        alu_pend = 1'b0;
  logic [15:0] alu_pend_val = '0;
  logic        alu_block = 1'b0;
  assign alu_done = (alu_cnt == 0) && !alu_block;

  always @(posedge clk) begin
    if (alu_start) begin
      alu_pend     <= 1'b1;
      alu_pend_val <= fx(alu_op, alu_a, alu_b);
    end else if (alu_pend) begin
      alu_pend <= 1'b0;
      alu_cnt  <= 3;
    end else if (alu_cnt > 0) begin
      alu_cnt <= alu_cnt - 1;
      if (alu_cnt == 1) alu_result <= alu_pend_val;
    end
  end

  typedef struct { logic [2:0] op; logic [15:0] a; logic [15:0] b; } alu_exp_t;
  typedef struct { logic [15:0] res; logic err; } done_exp_t;
  alu_exp_t  q_op[$];
  done_exp_t q_done[$];
  logic [15:0] model_last = '0;

  task automatic model_eval(input logic [15:0] xv);
    logic [15:0] st[$];
    logic [2:0]  k;
    logic [15:0] a, b;
    done_exp_t   d;
    d.err = 1'b1;
    d.res = model_last;
    for (int pc = 0; pc < 256; pc++) begin
      k = rom[pc][18:16];
      if (k == K_CONST || k == K_X) begin
        if (st.size() == 8) break;
        st.push_back((k == K_X) ? xv : rom[pc][15:0]);
      end else if (k >= K_ADD && k <= K_DIV) begin
        if (st.size() < 2) break;
        b = st.pop_back();
        a = st.pop_back();
        q_op.push_back('{op: k - 3'd2, a: a, b: b});
        st.push_back(fx(k - 3'd2, a, b));
      end else begin
        if (k == K_END && st.size() == 1) begin
          d.err = 1'b0;
          d.res = st[0];
          model_last = st[0];
        end
        break;
      end
    end
    q_done.push_back(d);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (alu_start) begin
        n_alu++;
        if (q_op.size() == 0) chk("unexpected_alu_start", 1, 0);
        else begin
          alu_exp_t e;
          e = q_op.pop_front();
          chk("alu_op", 32'(alu_op), 32'(e.op));
          chk("alu_a", 32'(alu_a), 32'(e.a));
          chk("alu_b", 32'(alu_b), 32'(e.b));
        end
      end
      if (done) begin
        if (q_done.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          done_exp_t d;
          d = q_done.pop_front();
          chk("result", 32'(result), 32'(d.res));
          chk("error", 32'(error), 32'(d.err));
          chk("busy_in_done", 32'(busy), 0);
        end
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = {K_BAD, 16'h0000};
  endtask

  task automatic ld(input int idx, input logic [2:0] k, input logic [15:0] imm);
    rom[idx] = {k, imm};
  endtask

  task automatic pulse_start(input logic [15:0] xv);
    @(negedge clk);
    x = xv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the cycle index (1 = first cycle after acceptance) in which done is seen.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic run(input logic [15:0] xv, output int cyc);
    model_eval(xv);
    pulse_start(xv);
    wait_done(cyc);
  endtask

  int cyc, a0;

  initial begin
    clear_rom();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_alu_start", 32'(alu_start), 0);
    chk("rst_prog_addr", 32'(prog_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // x * 2.0 with x = 1.5
    clear_rom();
    ld(0, K_X, 0); ld(1, K_CONST, 16'h0200); ld(2, K_MUL, 0); ld(3, K_END, 0);
    a0 = n_alu;
    run(16'h0180, cyc);
    chk("mul_result_lit", 32'(result), 32'h0300);
    chk("mul_error_lit", 32'(error), 0);
    chk("mul_latency", cyc, 16);
    @(negedge clk);
    chk("mul_alu_count", n_alu - a0, 1);

    clear_rom();
    ld(0, K_CONST, 16'h0500); ld(1, K_CONST, 16'h0200); ld(2, K_SUB, 0); ld(3, K_END, 0);
    run(16'h0000, cyc);
    chk("sub_result_lit", 32'(result), 32'h0300);

    ld(2, K_DIV, 0);
    run(16'h0000, cyc);
    chk("div_result_lit", 32'(result), 32'h0280);

    // binop on a one-entry stack
    clear_rom();
    ld(0, K_CONST, 16'h0100); ld(1, K_ADD, 0);
    a0 = n_alu;
    run(16'h0000, cyc);
    chk("underflow_error_lit", 32'(error), 1);
    chk("underflow_result_kept", 32'(result), 32'h0280);
    @(negedge clk);
    chk("underflow_alu_count", n_alu - a0, 0);

    // nine pushes overflow on the ninth decode
    clear_rom();
    for (int i = 0; i < 9; i++) ld(i, K_CONST, 16'(i + 1));
    ld(9, K_END, 0);
    run(16'h0000, cyc);
    chk("overflow_error_lit", 32'(error), 1);
    chk("overflow_latency", cyc, 19);

    // full stack then reduce: 1+..+8 = 36
    clear_rom();
    for (int i = 0; i < 8; i++) ld(i, K_CONST, 16'(i + 1));
    for (int i = 8; i < 15; i++) ld(i, K_ADD, 0);
    ld(15, K_END, 0);
    run(16'h0000, cyc);
    chk("full_sum_lit", 32'(result), 32'h0024);
    chk("full_sum_error", 32'(error), 0);

    // END with two entries and illegal opcode
    clear_rom();
    ld(0, K_X, 0); ld(1, K_X, 0); ld(2, K_END, 0);
    run(16'h0700, cyc);
    chk("end_sp2_error", 32'(error), 1);
    clear_rom();
    ld(0, K_X, 0); ld(1, K_BAD, 0);
    run(16'h0700, cyc);
    chk("illegal_error", 32'(error), 1);

    // reset during ALU wait of a DIV
    clear_rom();
    ld(0, K_CONST, 16'h0500); ld(1, K_CONST, 16'h0200); ld(2, K_DIV, 0); ld(3, K_END, 0);
    model_eval(16'h0000);
    pulse_start(16'h0000);
    cyc = 0;
    while (!alu_start && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("div_alu_start_seen", 32'(alu_start), 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    alu_block = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_alu_start", 32'(alu_start), 0);
    chk("async_rst_result", 32'(result), 0);
    q_op.delete();
    q_done.delete();
    model_last = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ld(2, K_SUB, 0);
    a0 = n_alu;
    model_eval(16'h0000);
    pulse_start(16'h0000);
    repeat (12) @(negedge clk);
    chk("stall_no_alu_start", n_alu - a0, 0);
    chk("stall_busy", 32'(busy), 1);
    alu_block = 1'b0;
    wait_done(cyc);
    chk("after_rst_sub_lit", 32'(result), 32'h0300);

    // start held high across two evaluations with x changing in between
    clear_rom();
    ld(0, K_X, 0); ld(1, K_CONST, 16'h0100); ld(2, K_ADD, 0); ld(3, K_END, 0);
    model_eval(16'h0100);
    model_eval(16'h0300);
    @(negedge clk);
    x = 16'h0100;
    start = 1'b1;
    @(negedge clk);
    x = 16'h0300;
    wait_done(cyc);
    chk("held_first_lit", 32'(result), 32'h0200);
    @(negedge clk);
    chk("held_gap_busy", 32'(busy), 0);
    @(negedge clk);
    chk("held_second_busy", 32'(busy), 1);
    start = 1'b0;
    wait_done(cyc);
    chk("held_second_lit", 32'(result), 32'h0400);

    repeat (3) @(negedge clk);
    chk("op_queue_empty", q_op.size(), 0);
    chk("done_queue_empty", q_done.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
